// File: rtl/serial_adder_module_if.sv
// Operand/result bundle for the bit-serial adder.
// SERIAL_ADDER_SUBTRACT_EN adds the sub request line.
interface serial_adder_module_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             carry_in;
`ifdef SERIAL_ADDER_SUBTRACT_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;

    modport master (
        output start, a_in, b_in, carry_in,
`ifdef SERIAL_ADDER_SUBTRACT_EN
        output sub,
`endif
        input  busy, done, sum_out, carry_out
    );

    modport slave (
        input  start, a_in, b_in, carry_in,
`ifdef SERIAL_ADDER_SUBTRACT_EN
        input  sub,
`endif
        output busy, done, sum_out, carry_out
    );
endinterface

// File: rtl/serial_adder_module.sv
// Bit-serial adder: one full-adder slice plus carry flop, LSB first, one bit per clock.
// Define SERIAL_ADDER_SUBTRACT_EN to add a sub input (a - b via ~b and carry-in of 1).
module serial_adder_module #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_module_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum_out;
    logic             r_carry_out;

    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic             w_s;
    logic             w_c_next;
    logic [WIDTH-1:0] w_sum_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

`ifdef SERIAL_ADDER_SUBTRACT_EN
    assign w_b_load = bus.sub ? ~bus.b_in : bus.b_in;
    assign w_c_load = bus.sub ? 1'b1 : bus.carry_in;
`else
    assign w_b_load = bus.b_in;
    assign w_c_load = bus.carry_in;
`endif

    assign w_s        = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
    assign w_c_next   = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_c) | (r_b_sh[0] & r_c);
    assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_c         <= 1'b0;
            r_cnt       <= '0;
            r_sum_out   <= '0;
            r_carry_out <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= bus.a_in;
            r_b_sh   <= w_b_load;
            r_c      <= w_c_load;
            r_sum_sh <= '0;
            r_cnt    <= '0;
        end else if (r_state == SHIFT) begin
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_c      <= w_c_next;
            r_sum_sh <= w_sum_next;
            // Hold the counter on the final bit so it never wraps.
            if (w_last) begin
                r_sum_out   <= w_sum_next;
                r_carry_out <= w_c_next;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.busy      = (r_state == SHIFT);
    assign bus.done      = (r_state == DONE);
    assign bus.sum_out   = r_sum_out;
    assign bus.carry_out = r_carry_out;
endmodule

// File: tb/tb_serial_adder_module.sv
// Scoreboard bench for serial_adder_module: random and directed operands against
// an arithmetic reference, with a cycle timeline model for busy/done.
module tb_serial_adder_module;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    serial_adder_module_if #(.WIDTH(W)) bus ();
    serial_adder_module #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int n_cmp = 0;
    int n_err = 0;

    logic [W:0] exp_q[$];
    logic [W:0] hold = '0;
    int         m_cnt = 0;   // 0 idle, 1..W busy cycles, W+1 done cycle
    logic       prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic cin, input logic sb);
        logic [W-1:0] d;
        if (sb) begin
            d = a - b;
            return {(a >= b), d};
        end
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    function automatic logic cur_sub();
`ifdef SERIAL_ADDER_SUBTRACT_EN
        return bus.sub;
`else
        return 1'b0;
`endif
    endfunction

    // Reference timeline: accepts on an idle edge with start, records the answer.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n) begin
                if (m_cnt == 0) begin
                    if (bus.start) begin
                        exp_q.push_back(ref_result(bus.a_in, bus.b_in, bus.carry_in, cur_sub()));
                        m_cnt = 1;
                    end
                end else if (m_cnt == W + 1) begin
                    m_cnt = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge rst_n);
            m_cnt = 0;
            exp_q.delete();
            hold = '0;
        end
    end

    // Monitor: timing against the timeline, results popped whenever done shows.
    initial begin
        logic [W:0] e;
        forever begin
            @(negedge clk);
            check("busy", 32'(bus.busy), 32'(m_cnt >= 1 && m_cnt <= W));
            check("done", 32'(bus.done), 32'(m_cnt == W + 1));
            if (bus.done) begin
                check("done_single", 32'(prev_done), 32'd0);
                if (exp_q.size() == 0) begin
                    check("queue_empty_on_done", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    hold = e;
                    check("sum_out", 32'(bus.sum_out), 32'(e[W-1:0]));
                    check("carry_out", 32'(bus.carry_out), 32'(e[W]));
                    $display("txn sum=0x%02h carry=%0d", bus.sum_out, bus.carry_out);
                end
            end else begin
                check("sum_hold", 32'(bus.sum_out), 32'(hold[W-1:0]));
                check("carry_hold", 32'(bus.carry_out), 32'(hold[W]));
            end
            prev_done = bus.done;
        end
    end

    task automatic scramble();
        bus.a_in     = W'($urandom);
        bus.b_in     = W'($urandom);
        bus.carry_in = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUBTRACT_EN
        bus.sub      = 1'($urandom_range(0, 1));
`endif
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_cnt != 0 && n < 200) begin
            @(negedge clk);
            scramble();
            n++;
        end
        if (m_cnt != 0) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sb);
        wait_idle();
        bus.a_in     = a;
        bus.b_in     = b;
        bus.carry_in = cin;
`ifdef SERIAL_ADDER_SUBTRACT_EN
        bus.sub      = sb;
`else
        if (sb) $display("note: sub request ignored in add-only build");
`endif
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"},  32'(bus.busy), 32'd0);
        check({tag, "_done"},  32'(bus.done), 32'd0);
        check({tag, "_sum"},   32'(bus.sum_out), 32'd0);
        check({tag, "_carry"}, 32'(bus.carry_out), 32'd0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.a_in     = '0;
        bus.b_in     = '0;
        bus.carry_in = 1'b0;
`ifdef SERIAL_ADDER_SUBTRACT_EN
        bus.sub      = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("post_reset");

        do_op(8'h5A, 8'h33, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        do_op(8'h00, 8'h00, 1'b0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b0, 1'b0);
        do_op(8'h80, 8'h80, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);

        // Back-to-back with operands changing every cycle.
        wait_idle();
        bus.start = 1'b1;
        for (int i = 0; i < 5 * (W + 2) + 1; i++) begin
            scramble();
            @(negedge clk);
        end
        bus.start = 1'b0;
        wait_idle();

        // Abort on the 4th shift cycle.
        bus.a_in = 8'h12;
        bus.b_in = 8'h34;
        bus.carry_in = 1'b0;
`ifdef SERIAL_ADDER_SUBTRACT_EN
        bus.sub = 1'b0;
`endif
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 3) @(negedge clk);
        check_zero_outputs("after_abort");
        do_op(8'h12, 8'h34, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUBTRACT_EN
        do_op(8'h10, 8'h01, 1'b0, 1'b1);
        do_op(8'h01, 8'h02, 1'b1, 1'b1);
        do_op(8'h55, 8'h55, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`endif

        wait_idle();
        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
